lookup3_stream: RTL and testbench

- Streaming Bob Jenkins lookup3 (hashlittle) engine; successor to the fixed 12-byte lookup3 block.
- Accepts keys of any length from 0 to 2^LEN_W-1 bytes as a sequence of 96-bit beats, with a per-key seed.
- Uses a valid/ready handshake on both sides; returns one 32-bit hash per key.
- Sits in front of the hash-table index logic; one key in flight at a time.

---
 rtl/lookup3_pkg.sv | 42 ++++
 rtl/lookup3_round.sv | 77 +++++++
 rtl/lookup3_stream.sv | 169 ++++++++++++++++
 tb/tb_lookup3_stream.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lookup3_pkg.sv
// Shared constants, types and helpers for the streaming lookup3 (hashlittle) engine.
package lookup3_pkg;

  // Seed constant that hashlittle folds into a, b and c before any key data.
  localparam logic [31:0] JHASH_GOLDEN = 32'hdeadbeef;

  // Top-level control states.
  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    MIX,
    FINAL,
    DONE
  } state_t;

  // Operation selector for the round datapath.
  typedef enum logic {
    OP_MIX,
    OP_FINAL
  } op_t;

  // 32-bit left rotate; the upper half of the doubled word carries the wrapped bits.
  function automatic logic [31:0] rot(input logic [31:0] x, input int unsigned k);
    logic [63:0] d;
    d = {x, x} << k;
    return d[63:32];
  endfunction

  // Byte-enable mask for one 12-byte beat: bytes at index >= rem are cleared,
  // which reproduces the hashlittle tail switch for partial beats.
  function automatic logic [95:0] byte_mask(input logic [31:0] rem);
    logic [95:0] m;
    m = '0;
    for (int i = 0; i < 12; i++) begin
      if (rem > i) begin
        m[8*i +: 8] = 8'hff;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/lookup3_round.sv
// Combinational lookup3 mix()/final() datapath. With SPLIT set, each operation is
// cut at its midpoint and the half input picks which part is evaluated.
module lookup3_round
  import lookup3_pkg::*;
#(
  parameter int SPLIT = 0
) (
  input  op_t         op,
  input  logic        half,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out
);

  localparam bit SPLIT_EN = (SPLIT != 0);

  logic        run_first;
  logic        run_second;
  logic [31:0] ma, mb, mc;
  logic [31:0] fa, fb, fc;

  // Unsplit: both halves chain in one cycle. Split: half 0 runs the first part,
  // half 1 runs the second part on the registered intermediate.
  assign run_first  = !SPLIT_EN || !half;
  assign run_second = !SPLIT_EN || half;

  // mix(): six subrounds, three per half.
  always_comb begin
    ma = a_in;
    mb = b_in;
    mc = c_in;
    if (run_first) begin
      ma = ma - mc;  ma = ma ^ rot(mc, 4);   mc = mc + mb;
      mb = mb - ma;  mb = mb ^ rot(ma, 6);   ma = ma + mc;
      mc = mc - mb;  mc = mc ^ rot(mb, 8);   mb = mb + ma;
    end
    if (run_second) begin
      ma = ma - mc;  ma = ma ^ rot(mc, 16);  mc = mc + mb;
      mb = mb - ma;  mb = mb ^ rot(ma, 19);  ma = ma + mc;
      mc = mc - mb;  mc = mc ^ rot(mb, 4);   mb = mb + ma;
    end
  end

  // final(): seven steps, four in the first half and three in the second.
  always_comb begin
    fa = a_in;
    fb = b_in;
    fc = c_in;
    if (run_first) begin
      fc = fc ^ fb;  fc = fc - rot(fb, 14);
      fa = fa ^ fc;  fa = fa - rot(fc, 11);
      fb = fb ^ fa;  fb = fb - rot(fa, 25);
      fc = fc ^ fb;  fc = fc - rot(fb, 16);
    end
    if (run_second) begin
      fa = fa ^ fc;  fa = fa - rot(fc, 4);
      fb = fb ^ fa;  fb = fb - rot(fa, 14);
      fc = fc ^ fb;  fc = fc - rot(fb, 24);
    end
  end

  // Select the requested operation's result.
  always_comb begin
    a_out = ma;
    b_out = mb;
    c_out = mc;
    if (op == OP_FINAL) begin
      a_out = fa;
      b_out = fb;
      c_out = fc;
    end
  end

endmodule

// File: rtl/lookup3_stream.sv
// Streaming lookup3 hashlittle engine: absorbs a key as 96-bit beats, one key in
// flight, and returns the 32-bit hash through a valid/ready output.
module lookup3_stream
  import lookup3_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int SPLIT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LEN_W-1:0] in_len,
  input  logic [31:0]      in_seed,
  input  logic [31:0]      in_k0,
  input  logic [31:0]      in_k1,
  input  logic [31:0]      in_k2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_hash
);

  localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(12);

  state_t           state_reg, state_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  logic [31:0]      c_reg, c_next;
  logic [LEN_W-1:0] rem_reg, rem_next;
  logic             half_reg, half_next;
  logic [31:0]      hash_reg, hash_next;

  logic             beat_fire;
  logic             first_beat;
  logic             last_half;
  logic [LEN_W-1:0] len_eff;
  logic [95:0]      words;
  logic [31:0]      init_val;
  logic [31:0]      ra, rb, rc;
  op_t              op;

  // Input side is open only while waiting for a beat, and never during reset.
  assign in_ready   = !RST && (state_reg == IDLE || state_reg == ABSORB);
  assign out_valid  = (state_reg == DONE);
  assign out_hash   = hash_reg;

  assign beat_fire  = in_valid && in_ready;
  assign first_beat = (state_reg == IDLE);
  assign init_val   = JHASH_GOLDEN + 32'(in_len) + in_seed;

  // Length and seed only matter on the first beat; later beats mask from rem.
  assign len_eff    = first_beat ? in_len : rem_reg;
  assign words      = {in_k2, in_k1, in_k0} & byte_mask(32'(len_eff));

  assign last_half  = (SPLIT == 0) || half_reg;
  assign op         = (state_reg == FINAL) ? OP_FINAL : OP_MIX;

  lookup3_round #(
    .SPLIT(SPLIT)
  ) u_round (
    .op   (op),
    .half (half_reg),
    .a_in (a_reg),
    .b_in (b_reg),
    .c_in (c_reg),
    .a_out(ra),
    .b_out(rb),
    .c_out(rc)
  );

  // Next-state and datapath updates for the key-absorb / mix / final sequence.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    rem_next   = rem_reg;
    half_next  = half_reg;
    hash_next  = hash_reg;
    case (state_reg)
      IDLE: begin
        if (beat_fire) begin
          // An empty key masks every word to zero, so a/b/c stay at the init value.
          a_next    = init_val + words[31:0];
          b_next    = init_val + words[63:32];
          c_next    = init_val + words[95:64];
          rem_next  = in_len;
          half_next = 1'b0;
          if (in_len == '0) begin
            // Empty key bypasses final(); the hash is the init value itself.
            hash_next  = init_val;
            state_next = DONE;
          end else if (in_len > BEAT_BYTES) begin
            state_next = MIX;
          end else begin
            state_next = FINAL;
          end
        end
      end
      ABSORB: begin
        if (beat_fire) begin
          a_next    = a_reg + words[31:0];
          b_next    = b_reg + words[63:32];
          c_next    = c_reg + words[95:64];
          half_next = 1'b0;
          if (rem_reg > BEAT_BYTES) begin
            state_next = MIX;
          end else begin
            state_next = FINAL;
          end
        end
      end
      MIX: begin
        a_next = ra;
        b_next = rb;
        c_next = rc;
        if (last_half) begin
          rem_next   = rem_reg - BEAT_BYTES;
          half_next  = 1'b0;
          state_next = ABSORB;
        end else begin
          half_next = 1'b1;
        end
      end
      FINAL: begin
        a_next = ra;
        b_next = rb;
        c_next = rc;
        if (last_half) begin
          hash_next  = rc;
          half_next  = 1'b0;
          state_next = DONE;
        end else begin
          half_next = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any key or pending result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      rem_reg   <= '0;
      half_reg  <= 1'b0;
      hash_reg  <= '0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      rem_reg   <= rem_next;
      half_reg  <= half_next;
      hash_reg  <= hash_next;
    end
  end

endmodule

// File: tb/tb_lookup3_stream.sv
// Directed bench for lookup3_stream: one unsplit and one split engine, driven from a
// table of keys with known hashlittle results plus a mid-key reset sequence.
module tb_lookup3_stream;

  logic        CLK;
  logic        RST;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [7:0]  in_len  [2];
  logic [31:0] in_seed [2];
  logic [31:0] in_k0   [2];
  logic [31:0] in_k1   [2];
  logic [31:0] in_k2   [2];
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [31:0] out_hash [2];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Unit 0 is the single-cycle build, unit 1 the split build.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    lookup3_stream #(
      .LEN_W(8),
      .SPLIT(gi)
    ) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (in_valid[gi]),
      .in_ready (in_ready[gi]),
      .in_len   (in_len[gi]),
      .in_seed  (in_seed[gi]),
      .in_k0    (in_k0[gi]),
      .in_k1    (in_k1[gi]),
      .in_k2    (in_k2[gi]),
      .out_valid(out_valid[gi]),
      .out_ready(out_ready[gi]),
      .out_hash (out_hash[gi])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    string       key;
    logic [31:0] seed;
    int          gap;
    int          stall;
    logic [31:0] hash;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Little-endian word of key bytes base..base+3; bytes past the key are 0xFF so
  // that any masking error changes the hash.
  function automatic logic [31:0] key_word(input string key, input int base);
    logic [31:0] w;
    for (int bi = 0; bi < 4; bi++) begin
      if (base + bi < key.len()) w[8*bi +: 8] = key[base + bi];
      else                       w[8*bi +: 8] = 8'hff;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Send one table key to unit u, then collect and consume the hash.
  task automatic run_vec(input int u, input int vi);
    string       key;
    int          len, nbeats, acc, acc_prev, lat, n, exp_lat;
    logic [31:0] exp_hash;
    key      = vecs[vi].key;
    exp_hash = vecs[vi].hash;
    len      = key.len();
    nbeats   = (len == 0) ? 1 : (len + 11) / 12;
    // Empty keys skip final() and land in DONE one cycle after the beat.
    exp_lat  = (len == 0) ? 1 : 2 + u;
    acc      = cyc;
    acc_prev = cyc;
    for (int bt = 0; bt < nbeats; bt++) begin
      in_valid[u] = 1'b1;
      in_k0[u]    = key_word(key, bt*12);
      in_k1[u]    = key_word(key, bt*12 + 4);
      in_k2[u]    = key_word(key, bt*12 + 8);
      // Length and seed on continuation beats are junk and must be ignored.
      in_len[u]   = (bt == 0) ? 8'(len) : 8'hee;
      in_seed[u]  = (bt == 0) ? vecs[vi].seed : 32'h5a5a5a5a;
      n = 0;
      while (!in_ready[u] && n < 40) begin
        tick();
        n++;
      end
      if (!in_ready[u]) begin
        check($sformatf("accept_timeout u%0d %s", u, vecs[vi].name), 32'(in_ready[u]), 32'd1);
        in_valid[u] = 1'b0;
        return;
      end
      tick();
      acc = cyc;
      in_valid[u] = 1'b0;
      if (bt > 0 && vecs[vi].gap == 0)
        check($sformatf("beat_interval u%0d %s", u, vecs[vi].name), 32'(acc - acc_prev), 32'(2 + u));
      acc_prev = acc;
      if (bt < nbeats - 1) begin
        check($sformatf("early_out_valid u%0d %s", u, vecs[vi].name), 32'(out_valid[u]), 32'd0);
        repeat (vecs[vi].gap) tick();
      end
    end
    n = 0;
    while (!out_valid[u] && n < 40) begin
      tick();
      n++;
    end
    lat = cyc - acc + 1;
    check($sformatf("out_valid u%0d %s", u, vecs[vi].name), 32'(out_valid[u]), 32'd1);
    check($sformatf("latency u%0d %s", u, vecs[vi].name), 32'(lat), 32'(exp_lat));
    check($sformatf("hash u%0d %s", u, vecs[vi].name), out_hash[u], exp_hash);
    check($sformatf("in_ready_done u%0d %s", u, vecs[vi].name), 32'(in_ready[u]), 32'd0);
    // Hold the result; offer a junk beat meanwhile, which must not be taken.
    if (vecs[vi].stall > 0) begin
      in_valid[u] = 1'b1;
      in_len[u]   = 8'd5;
      in_k0[u]    = 32'h01234567;
    end
    for (int s = 0; s < vecs[vi].stall; s++) begin
      tick();
      check($sformatf("stall_valid u%0d %s", u, vecs[vi].name), 32'(out_valid[u]), 32'd1);
      check($sformatf("stall_hash u%0d %s", u, vecs[vi].name), out_hash[u], exp_hash);
      check($sformatf("stall_in_ready u%0d %s", u, vecs[vi].name), 32'(in_ready[u]), 32'd0);
    end
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b1;
    tick();
    out_ready[u] = 1'b0;
    check($sformatf("consumed u%0d %s", u, vecs[vi].name), 32'(out_valid[u]), 32'd0);
    check($sformatf("ready_after u%0d %s", u, vecs[vi].name), 32'(in_ready[u]), 32'd1);
    $display("txn %-12s unit%0d len=%0d seed=%08h hash=%08h latency=%0d",
             vecs[vi].name, u, len, vecs[vi].seed, out_hash[u], lat);
  endtask

  // Reset pulsed while unit u waits in ABSORB after the first beat, then a full key.
  task automatic rst_mid_key(input int u);
    string key;
    int    n;
    key         = vecs[2].key;
    in_valid[u] = 1'b1;
    in_len[u]   = 8'd30;
    in_seed[u]  = 32'd0;
    in_k0[u]    = key_word(key, 0);
    in_k1[u]    = key_word(key, 4);
    in_k2[u]    = key_word(key, 8);
    n = 0;
    while (!in_ready[u] && n < 40) begin
      tick();
      n++;
    end
    tick();
    in_valid[u] = 1'b0;
    check($sformatf("rst_seq_no_out u%0d", u), 32'(out_valid[u]), 32'd0);
    n = 0;
    while (!in_ready[u] && n < 40) begin
      tick();
      n++;
    end
    check($sformatf("rst_seq_absorb u%0d", u), 32'(in_ready[u]), 32'd1);
    RST = 1'b1;
    #1;
    check($sformatf("rst_seq_ready_low u%0d", u), 32'(in_ready[u]), 32'd0);
    @(posedge CLK);
    #1;
    check($sformatf("rst_seq_out_valid u%0d", u), 32'(out_valid[u]), 32'd0);
    check($sformatf("rst_seq_out_hash u%0d", u), out_hash[u], 32'd0);
    RST = 1'b0;
    #1;
    check($sformatf("rst_seq_ready_back u%0d", u), 32'(in_ready[u]), 32'd1);
    run_vec(u, 2);
  endtask

  initial begin
    vecs[0] = '{name: "empty_s0",   key: "", seed: 32'h00000000, gap: 0, stall: 0, hash: 32'hdeadbeef};
    vecs[1] = '{name: "empty_sdb",  key: "", seed: 32'hdeadbeef, gap: 0, stall: 0, hash: 32'hbd5b7dde};
    vecs[2] = '{name: "four_s0",    key: "Four score and seven years ago", seed: 32'd0, gap: 0, stall: 0, hash: 32'h17770551};
    vecs[3] = '{name: "four_s1",    key: "Four score and seven years ago", seed: 32'd1, gap: 0, stall: 0, hash: 32'hcd628161};
    vecs[4] = '{name: "four_stall", key: "Four score and seven years ago", seed: 32'd0, gap: 5, stall: 4, hash: 32'h17770551};

    RST       = 1'b1;
    in_valid  = '0;
    out_ready = '0;
    for (int u = 0; u < 2; u++) begin
      in_len[u]  = '0;
      in_seed[u] = '0;
      in_k0[u]   = '0;
      in_k1[u]   = '0;
      in_k2[u]   = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int u = 0; u < 2; u++) begin
      check($sformatf("reset_in_ready u%0d", u), 32'(in_ready[u]), 32'd0);
      check($sformatf("reset_out_valid u%0d", u), 32'(out_valid[u]), 32'd0);
      check($sformatf("reset_out_hash u%0d", u), out_hash[u], 32'd0);
    end
    RST = 1'b0;
    #1;
    for (int u = 0; u < 2; u++)
      check($sformatf("release_in_ready u%0d", u), 32'(in_ready[u]), 32'd1);

    for (int u = 0; u < 2; u++) begin
      for (int vi = 0; vi < 5; vi++) run_vec(u, vi);
      rst_mid_key(u);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
